// File: rtl/smbus_tx_drain.sv
// rtl/smbus_tx_drain.sv - SMBus controller write engine draining the TX byte FIFO onto open-drain SCL/SDA
module smbus_tx_drain #(
  parameter int CLK_DIV    = 125,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [6:0]            slave_addr,
  input  logic [CNT_W-1:0]      byte_count,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  output logic                  underrun
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, ACK, STOP} state_t;
  state_t state, state_next;

  logic [DIV_W-1:0]      div;
  logic [1:0]            q;
  logic [DATA_WIDTH-1:0] shift;
  logic [2:0]            bit_cnt;
  logic [CNT_W-1:0]      remaining;
  logic                  scl_seen;
  logic                  ack_bit;
  logic                  in_cell;
  logic                  stretch;
  logic                  qtick;
  logic                  q_end;
  logic                  load;

  // q2 of any clocked quarter waits for the target to release SCL; the divider is frozen meanwhile
  assign in_cell = (state == ADDR) || (state == DATA) || (state == ACK) || (state == STOP);
  assign stretch = in_cell && (q == 2'd2) && !scl_seen && !scl_in;
  assign qtick   = (state != IDLE) && !stretch && (div == DIV_MAX);
  assign q_end   = qtick && (q == 2'd3);
  assign load    = (state == ACK) && q_end && !ack_bit && (remaining != '0) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (start) state_next = START;
      START:       if (qtick && (q == 2'd2)) state_next = ADDR;
      ADDR, DATA:  if (q_end && (bit_cnt == 3'd0)) state_next = ACK;
      ACK: begin
        if (q_end) begin
          if (ack_bit || (remaining == '0) || fifo_empty) state_next = STOP;
          else                                              state_next = DATA;
        end
      end
      STOP:        if (q_end) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    fifo_rd_en = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      START: begin
        sda_oe = (q != 2'd0);
        scl_oe = (q == 2'd2);
      end
      ADDR, DATA: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
        sda_oe = ~shift[DATA_WIDTH-1];
      end
      ACK: begin
        scl_oe     = (q == 2'd0) || (q == 2'd3);
        fifo_rd_en = load;
      end
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = !((q == 2'd3) || ((q == 2'd2) && scl_seen));
        done   = q_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      q         <= 2'd0;
      shift     <= '0;
      bit_cnt   <= 3'd0;
      remaining <= '0;
      scl_seen  <= 1'b0;
      ack_bit   <= 1'b0;
      nack      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if ((state == IDLE) || stretch || qtick) div <= '0;
      else                                     div <= div + 1'b1;

      if (qtick) q <= (state_next != state) ? 2'd0 : q + 2'd1;

      if (qtick)                                  scl_seen <= 1'b0;
      else if (in_cell && (q == 2'd2) && scl_in)  scl_seen <= 1'b1;

      if ((state == ACK) && (q == 2'd2) && scl_in && !scl_seen) ack_bit <= sda_in;

      if ((state == IDLE) && start) begin
        shift     <= {slave_addr, 1'b0};
        bit_cnt   <= 3'd7;
        remaining <= byte_count;
        nack      <= 1'b0;
        underrun  <= 1'b0;
      end else if (((state == ADDR) || (state == DATA)) && q_end) begin
        shift <= {shift[DATA_WIDTH-2:0], 1'b0};
        if (bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
      end else if ((state == ACK) && q_end) begin
        if (ack_bit) begin
          nack <= 1'b1;
        end else if (remaining != '0) begin
          if (fifo_empty) begin
            underrun <= 1'b1;
          end else begin
            shift     <= fifo_rd_data;
            remaining <= remaining - 1'b1;
            bit_cnt   <= 3'd7;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_smbus_tx_drain.sv
// tb/tb_smbus_tx_drain.sv - self-checking bench for smbus_tx_drain with FIFO and bus target models
module tb_smbus_tx_drain;
  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 6;
  localparam int QP      = 4 * CLK_DIV;
  localparam int STRETCH = 500;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [6:0]       slave_addr;
  logic [CNT_W-1:0] byte_count;
  logic [7:0]       fifo_rd_data;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             scl_in, sda_in, scl_oe, sda_oe;
  logic             busy, done, nack, underrun;
  logic             tgt_scl_low = 1'b0;
  logic             tgt_sda_low = 1'b0;

  always #5 clk = ~clk;

  assign scl_in = ~scl_oe & ~tgt_scl_low;
  assign sda_in = ~sda_oe & ~tgt_sda_low;

  smbus_tx_drain #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_addr(slave_addr), .byte_count(byte_count),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .nack(nack), .underrun(underrun)
  );

  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = fifo_mem[rd_ptr[3:0]];
  always @(posedge clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

  // Bus target: decodes START/STOP and bits, ACKs bytes, stretches SCL on request
  int cyc = 0, pops = 0, dones = 0, stops = 0, bad_pops = 0;
  int nack_byte = -1, stretch_byte = -1, stretch_left = 0;
  int bit_idx = 0, byte_idx = 0, rx_cnt = 0, rise_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_bytes [0:15];
  int rise_t [0:63];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (fifo_rd_en) pops++;
    if (fifo_rd_en && fifo_empty) bad_pops++;
    if (done) dones++;
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) tgt_scl_low = 1'b0;
    end
    if (prev_scl && scl_in && prev_sda && !sda_in) begin
      bit_idx = 0; byte_idx = 0; rx_cnt = 0; rise_cnt = 0;
    end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
      stops++;
    end else if (!prev_scl && scl_in) begin
      if (rise_cnt < 64) rise_t[rise_cnt] = cyc;
      rise_cnt++;
      if (bit_idx < 8) begin
        rx_sh = {rx_sh[6:0], sda_in};
        bit_idx++;
        if (bit_idx == 8 && rx_cnt < 16) begin
          rx_bytes[rx_cnt] = rx_sh;
          rx_cnt++;
        end
      end else begin
        bit_idx = 0;
        byte_idx++;
      end
    end else if (prev_scl && !scl_in) begin
      tgt_sda_low = (bit_idx == 8) && (byte_idx != nack_byte);
      if (byte_idx == stretch_byte && bit_idx == 3) begin
        tgt_scl_low  = 1'b1;
        stretch_left = STRETCH;
      end
    end
    prev_scl = scl_in;
    prev_sda = sda_in;
  end

  int errors = 0, checks = 0;
  int p0, d0, s0, b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    p0 = pops; d0 = dones; s0 = stops; b0 = bad_pops;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic do_start(input logic [6:0] a, input int bc);
    slave_addr = a;
    byte_count = CNT_W'(bc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int dur);
    dur = 0;
    while (dones == d0 && dur < 20000) begin
      tick();
      dur++;
    end
    if (dones == d0) check("done_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    logic [6:0]  addr;
    int          bc;
    int          nfifo;
    logic [23:0] data;
    int          nack_byte;
    bit          stretch;
    int          exp_pops;
    bit          exp_nack;
    bit          exp_und;
    int          exp_left;
    int          exp_rx;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int dur, badp;
    logic [7:0] exp_b;
    nack_byte    = v.nack_byte;
    stretch_byte = v.stretch ? 1 : -1;
    wr_ptr       = rd_ptr;
    for (int i = 0; i < v.nfifo; i++) push(v.data[23-8*i -: 8]);
    snap();
    do_start(v.addr, v.bc);
    wait_done(dur);
    tick(20);
    check($sformatf("%s.dones", tag), 32'(dones - d0), 32'(1));
    check($sformatf("%s.pops", tag), 32'(pops - p0), 32'(v.exp_pops));
    check($sformatf("%s.pop_empty", tag), 32'(bad_pops - b0), 32'(0));
    check($sformatf("%s.stops", tag), 32'(stops - s0), 32'(1));
    check($sformatf("%s.nack", tag), 32'(nack), 32'(v.exp_nack));
    check($sformatf("%s.underrun", tag), 32'(underrun), 32'(v.exp_und));
    check($sformatf("%s.busy", tag), 32'(busy), 32'(0));
    check($sformatf("%s.fifo_left", tag), 32'(wr_ptr - rd_ptr), 32'(v.exp_left));
    check($sformatf("%s.rx_cnt", tag), 32'(rx_cnt), 32'(v.exp_rx));
    for (int i = 0; i < v.exp_rx && i < 16; i++) begin
      exp_b = (i == 0) ? {v.addr, 1'b0} : v.data[23-8*(i-1) -: 8];
      check($sformatf("%s.rx_byte%0d", tag, i), 32'(rx_bytes[i]), 32'(exp_b));
    end
    if (v.stretch) begin
      check($sformatf("%s.stretch_delay", tag), 32'(dur >= 900), 32'(1));
    end else begin
      badp = 0;
      for (int i = 1; i < rise_cnt && i < 64; i++)
        if (rise_t[i] - rise_t[i-1] != QP) badp++;
      check($sformatf("%s.scl_period", tag), 32'(badp), 32'(0));
    end
  endtask

  vec_t vecs [6];

  initial begin
    int dur, n;
    vecs[0] = '{7'h50, 2, 2, 24'hA53C00, -1, 1'b0, 2, 1'b0, 1'b0, 0, 3};
    vecs[1] = '{7'h2A, 1, 1, 24'h110000,  0, 1'b0, 0, 1'b1, 1'b0, 1, 1};
    vecs[2] = '{7'h13, 3, 3, 24'hC3817E,  1, 1'b0, 1, 1'b1, 1'b0, 2, 2};
    vecs[3] = '{7'h7F, 3, 1, 24'hE70000, -1, 1'b0, 1, 1'b0, 1'b1, 0, 2};
    vecs[4] = '{7'h01, 2, 2, 24'h965A00, -1, 1'b1, 2, 1'b0, 1'b0, 0, 3};
    vecs[5] = '{7'h44, 0, 1, 24'hFF0000, -1, 1'b0, 0, 1'b0, 1'b0, 1, 1};

    rst = 1'b1; start = 1'b0; slave_addr = 7'h00; byte_count = '0;
    tick(3);
    check("rst.scl_oe", 32'(scl_oe), 32'(0));
    check("rst.sda_oe", 32'(sda_oe), 32'(0));
    check("rst.fifo_rd_en", 32'(fifo_rd_en), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.done", 32'(done), 32'(0));
    check("rst.nack", 32'(nack), 32'(0));
    check("rst.underrun", 32'(underrun), 32'(0));
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a data byte releases the bus at once
    nack_byte = -1; stretch_byte = -1;
    wr_ptr = rd_ptr;
    push(8'h12); push(8'h34);
    snap();
    do_start(7'h22, 2);
    n = 0;
    while (pops == p0 && n < 3000) begin tick(); n++; end
    check("rstmid.first_pop", 32'(pops - p0), 32'(1));
    tick(40);
    check("rstmid.busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    check("rstmid.scl_oe", 32'(scl_oe), 32'(0));
    check("rstmid.sda_oe", 32'(sda_oe), 32'(0));
    check("rstmid.busy", 32'(busy), 32'(0));
    rst = 1'b0;
    tick(10);

    run_vec(vecs[1], "nack_again");

    // A start while busy is ignored; the accepted start clears the sticky nack
    nack_byte = -1; stretch_byte = -1;
    wr_ptr = rd_ptr;
    push(8'h6D);
    snap();
    do_start(7'h35, 1);
    tick(5);
    check("ign.busy", 32'(busy), 32'(1));
    check("ign.nack_cleared", 32'(nack), 32'(0));
    tick(45);
    do_start(7'h0F, 0);
    wait_done(dur);
    tick(30);
    check("ign.dones", 32'(dones - d0), 32'(1));
    check("ign.pops", 32'(pops - p0), 32'(1));
    check("ign.rx_cnt", 32'(rx_cnt), 32'(2));
    check("ign.rx_addr", 32'(rx_bytes[0]), 32'(8'h6A));
    check("ign.rx_data", 32'(rx_bytes[1]), 32'(8'h6D));
    check("ign.busy_after", 32'(busy), 32'(0));
    check("ign.nack", 32'(nack), 32'(0));
    check("ign.underrun", 32'(underrun), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/smbus_tx_drain.md
Name: smbus_tx_drain

Overview:
- Read-side consumer of the SMBus controller's TX byte FIFO. It serializes FIFO bytes onto the open-drain SMBus as a controller write transaction: START, 7-bit address with W=0, N data bytes, STOP.
- Sits between the TX FIFO and the SCL/SDA pad drivers in the SMBus controller.
- Checks target ACKs, honours clock stretching, and reports done, nack and underrun status.

Parameters:
- CLK_DIV, 125, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal values are 2 or greater.
- DATA_WIDTH, 8, FIFO byte width; fixed at 8.
- CNT_W, 6, width of byte_count (up to 63 data bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse that begins a transaction; ignored unless busy=0
- slave_addr  in  7  target address, captured on start
- byte_count  in  CNT_W  number of data bytes to send, captured on start; 0 means address-only transaction
- fifo_rd_data  in  8  FIFO head byte, valid combinationally whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  single-cycle pop strobe
- scl_in  in  1  synchronized SCL pad level
- sda_in  in  1  synchronized SDA pad level
- scl_oe  out  1  1 = drive SCL low, 0 = release
- sda_oe  out  1  1 = drive SDA low, 0 = release
- busy  out  1  transaction in progress
- done  out  1  single-cycle pulse at end of transaction (success or abort)
- nack  out  1  sticky; set on NACK; cleared on next accepted start
- underrun  out  1  sticky; set when FIFO is empty at a byte load; cleared on next accepted start

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, fifo_rd_en=0, busy=0, done=0, nack=0, underrun=0; state=IDLE; phase counter=0; all counters=0. Reset mid-transaction releases both lines immediately, with no STOP issued.
- Quarter tick: a divider counts 0..CLK_DIV-1 and asserts qtick when it reaches CLK_DIV-1. The divider is held at 0 in IDLE and during a stretch wait.
- States: IDLE, START, ADDR, DATA, ACK, STOP.
- IDLE:
  - On start with busy=0: capture slave_addr and byte_count; clear nack and underrun; shift register <= {slave_addr,1'b0}; bit_cnt=7; busy=1; go to START.
  - A start while busy=1 is ignored.
- START:
  - q0: sda_oe=0, scl_oe=0. q1: sda_oe=1. q2: scl_oe=1. Then go to ADDR.
- Bit cell (ADDR, DATA, and ACK receive), 4 quarters:
  - q0: scl_oe=1; set sda_oe = ~shift[7] (ACK receive: sda_oe=0).
  - q1: scl_oe=0.
  - q2: wait until scl_in=1 (clock stretching); this wait has no timeout. Sample sda_in in the first cycle that scl_in=1 is seen.
  - q3: scl_oe=1.
  - After a bit, shift left and decrement bit_cnt. After bit 0, go to ACK.
- ACK, sampled sda_in=1 (NACK):
  - Set nack; go to STOP.
- ACK, sampled sda_in=0, remaining bytes=0:
  - Go to STOP.
- ACK, sampled sda_in=0, remaining bytes>0:
  - If fifo_empty=1: set underrun; go to STOP (no pop).
  - Otherwise: load shift <= fifo_rd_data; pulse fifo_rd_en for exactly one cycle; decrement remaining; bit_cnt=7; go to DATA.
- fifo_rd_en rules: asserted only in that load cycle and never while fifo_empty=1. Exactly one pop occurs per transmitted data byte.
- STOP:
  - q0: scl_oe=1, sda_oe=1. q1: scl_oe=0. q2: wait scl_in=1, then sda_oe=0.
  - q3: pulse done; busy=0; go to IDLE.
- Abort: NACK and underrun both take the STOP path, so exactly one done pulse is produced per accepted start.
- Remaining-byte counter: CNT_W bits, decremented only on a pop, never wraps.

Test Plan:
- Address plus 2 bytes, always ACK: FIFO holds 0xA5, 0x3C; slave_addr=0x50, byte_count=2 → SDA bit stream 0xA0, 0xA5, 0x3C with ACK slots. Expect 2 fifo_rd_en pulses, one done, nack=0, FIFO empty at the end, SCL period = 4*CLK_DIV.
- NACK on address: target leaves SDA high in the first ACK slot → no fifo_rd_en, STOP issued, nack=1, one done pulse.
- NACK on data byte 1 of 3: expect exactly 1 pop, nack=1, STOP issued, 2 bytes left in the FIFO.
- Underrun: byte_count=3 with only 1 byte in the FIFO → 1 pop, underrun=1, STOP after the first data ACK, fifo_rd_en never asserted while fifo_empty=1.
- Clock stretching: target holds scl_in low for 500 cycles during bit 3 of the data byte → data sampling is delayed, bit values and ordering are unchanged, no extra pops.
- Reset mid-DATA, then restart: scl_oe=sda_oe=0 and busy=0 on the next cycle. A start pulse during busy is ignored; a later start completes normally with nack and underrun cleared.
